// File: rtl/store_merge_unit.sv
// Store-side byte-lane writer: performs sb/sh/sw against a word-only data RAM.
// Byte and halfword stores read-modify-write the containing word; aligned words write directly.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [15:0] store_cnt
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [15:0] r_data;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;

  logic        w_accept;
  logic        w_bad;
  logic [31:0] w_merged;

  assign w_accept = req_valid & req_ready;

  // Misaligned halves/words and the reserved size never reach the RAM.
  always_comb begin
    w_bad = 1'b0;
    case (req_size)
      SZ_BYTE: w_bad = 1'b0;
      SZ_HALF: w_bad = req_addr[0];
      SZ_WORD: w_bad = (req_addr[1:0] != 2'b00);
      default: w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_next = ERR;
          end else if (req_size == SZ_WORD) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end
      READ:    w_next = MERGE;
      MERGE:   w_next = WRITE;
      WRITE:   w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Only the low halfword of the store data is ever needed after acceptance;
  // word stores go straight into the write-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= 32'h0;
      r_data  <= 16'h0;
      r_size  <= 2'b00;
      r_wdata <= 32'h0;
      r_cnt   <= 16'h0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_data[15:0];
        r_size <= req_size;
        if (req_size == SZ_WORD) begin
          r_wdata <= req_data;
        end
      end
      if (r_state == MERGE) begin
        r_wdata <= w_merged;
      end
      if (r_state == WRITE) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SZ_HALF) begin
      if (r_addr[1]) begin
        w_merged[31:16] = r_data;
      end else begin
        w_merged[15:0] = r_data;
      end
    end else begin
      case (r_addr[1:0])
        2'b00:   w_merged[7:0]   = r_data[7:0];
        2'b01:   w_merged[15:8]  = r_data[7:0];
        2'b10:   w_merged[23:16] = r_data[7:0];
        default: w_merged[31:24] = r_data[7:0];
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == IDLE) & ~reset;
    mem_re    = (r_state == READ);
    mem_we    = (r_state == WRITE);
    done      = (r_state == WRITE);
    err       = (r_state == ERR);
    mem_addr  = {r_addr[31:2], 2'b00};
    mem_wdata = r_wdata;
    store_cnt = r_cnt;
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: behavioural RAM plus a queue of expected writes,
// popped whenever the unit raises mem_we.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [15:0] store_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sbQ[$];
  wr_t         expWr;
  logic [31:0] ram    [0:255];
  logic [31:0] shadow [0:255];
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [15:0] expCnt;

  store_merge_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .store_cnt(store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM: read data valid the cycle after mem_re, writes land at the edge.
  always @(posedge clk) begin
    if (mem_re === 1'b1) mem_rdata <= ram[mem_addr[9:2]];
    if (mem_we === 1'b1) ram[mem_addr[9:2]] = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  function automatic logic [31:0] mergeModel(input logic [31:0] old, input logic [31:0] a,
                                             input logic [31:0] d, input logic [1:0] s);
    logic [31:0] mask;
    int          sh;
    if (s == 2'b00) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
    end else if (s == 2'b01) begin
      sh   = 16 * int'(a[1]);
      mask = 32'hFFFF << sh;
    end else begin
      return d;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    setReq(1'b1, 32'h70, 32'h5555_AAAA, 2'b10);
    tick();
    tick();
    nCompared++; if (req_ready !== 1'b0) begin nMismatched++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    nCompared++; if ({mem_re, mem_we, done, err} !== 4'b0) begin nMismatched++; $display("FAIL reset_strobes: got %b want 0000", {mem_re, mem_we, done, err}); end
    nCompared++; if (store_cnt !== 16'h0) begin nMismatched++; $display("FAIL reset_cnt: got %h want 0000", store_cnt); end
    nCompared++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin nMismatched++; $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    reset = 1'b0;
    setReq(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    tick();
    nCompared++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_no_accept: got we %b ready %b want 0 1", mem_we, req_ready); end
    expCnt = 16'h0;
  endtask

  task automatic test_word();
    setReq(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
    sbQ.push_back('{addr: 32'h10, data: 32'hDEAD_BEEF});
    tick();
    req_valid = 1'b0;
    nCompared++; if ({mem_we, done, mem_re, err, req_ready} !== 5'b11000) begin nMismatched++; $display("FAIL word_strobes: got %b want 11000", {mem_we, done, mem_re, err, req_ready}); end
    nCompared++;
    if (sbQ.size() == 0) begin nMismatched++; $display("FAIL word_sb: got write %h with empty queue", mem_wdata); end
    else begin
      expWr = sbQ.pop_front();
      if (mem_addr !== expWr.addr || mem_wdata !== expWr.data) begin
        nMismatched++; $display("FAIL word_sb: got %h@%h want %h@%h", mem_wdata, mem_addr, expWr.data, expWr.addr);
      end
    end
    tick();
    expCnt++;
    nCompared++; if (store_cnt !== expCnt || req_ready !== 1'b1) begin nMismatched++; $display("FAIL word_cnt: got cnt %h ready %b want %h 1", store_cnt, req_ready, expCnt); end
  endtask

  task automatic test_byte();
    ram[8] = 32'h1122_3344;
    setReq(1'b1, 32'h22, 32'hFFFF_FFAB, 2'b00);
    sbQ.push_back('{addr: 32'h20, data: 32'h11AB_3344});
    tick();
    req_valid = 1'b0;
    nCompared++; if (mem_re !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin nMismatched++; $display("FAIL byte_read: got re %b addr %h we %b want 1 00000020 0", mem_re, mem_addr, mem_we); end
    tick();
    nCompared++; if ({mem_re, mem_we, done} !== 3'b000) begin nMismatched++; $display("FAIL byte_merge: got %b want 000", {mem_re, mem_we, done}); end
    tick();
    nCompared++; if (mem_we !== 1'b1 || done !== 1'b1) begin nMismatched++; $display("FAIL byte_write: got we %b done %b want 1 1", mem_we, done); end
    nCompared++;
    if (sbQ.size() == 0) begin nMismatched++; $display("FAIL byte_sb: got write %h with empty queue", mem_wdata); end
    else begin
      expWr = sbQ.pop_front();
      if (mem_addr !== expWr.addr || mem_wdata !== expWr.data) begin
        nMismatched++; $display("FAIL byte_sb: got %h@%h want %h@%h", mem_wdata, mem_addr, expWr.data, expWr.addr);
      end
    end
    tick();
    expCnt++;
    nCompared++; if (store_cnt !== expCnt || req_ready !== 1'b1) begin nMismatched++; $display("FAIL byte_cnt: got cnt %h ready %b want %h 1", store_cnt, req_ready, expCnt); end
  endtask

  task automatic test_half();
    logic [31:0] addrs [2];
    logic [31:0] wants [2];
    addrs[0] = 32'h42; wants[0] = 32'h1234_BBBB;
    addrs[1] = 32'h40; wants[1] = 32'h1234_1234;
    ram[16] = 32'hAAAA_BBBB;
    for (int i = 0; i < 2; i++) begin
      setReq(1'b1, addrs[i], 32'h0000_1234, 2'b01);
      sbQ.push_back('{addr: 32'h40, data: wants[i]});
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      nCompared++;
      if (mem_we !== 1'b1 || sbQ.size() == 0) begin nMismatched++; $display("FAIL half_write%0d: got we %b queue %0d want 1", i, mem_we, sbQ.size()); end
      else begin
        expWr = sbQ.pop_front();
        if (mem_addr !== expWr.addr || mem_wdata !== expWr.data) begin
          nMismatched++; $display("FAIL half_sb%0d: got %h@%h want %h@%h", i, mem_wdata, mem_addr, expWr.data, expWr.addr);
        end
      end
      tick();
      expCnt++;
    end
    nCompared++; if (store_cnt !== expCnt) begin nMismatched++; $display("FAIL half_cnt: got %h want %h", store_cnt, expCnt); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h31; sizes[0] = 2'b01;
    addrs[1] = 32'h32; sizes[1] = 2'b10;
    addrs[2] = 32'h30; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      setReq(1'b1, addrs[i], 32'hFFFF_FFFF, sizes[i]);
      tick();
      req_valid = 1'b0;
      nCompared++; if ({err, mem_re, mem_we, done} !== 4'b1000) begin nMismatched++; $display("FAIL err%0d_pulse: got %b want 1000", i, {err, mem_re, mem_we, done}); end
      tick();
      nCompared++; if (req_ready !== 1'b1 || err !== 1'b0 || store_cnt !== expCnt) begin nMismatched++; $display("FAIL err%0d_after: got ready %b err %b cnt %h want 1 0 %h", i, req_ready, err, store_cnt, expCnt); end
    end
  endtask

  task automatic test_back_to_back();
    setReq(1'b1, 32'h50, 32'h0102_0304, 2'b10);
    sbQ.push_back('{addr: 32'h50, data: 32'h0102_0304});
    tick();
    setReq(1'b1, 32'h51, 32'h0000_00CC, 2'b00);
    sbQ.push_back('{addr: 32'h50, data: 32'h0102_CC04});
    nCompared++; if (req_ready !== 1'b0 || mem_we !== 1'b1) begin nMismatched++; $display("FAIL b2b_c1: got ready %b we %b want 0 1", req_ready, mem_we); end
    if (mem_we === 1'b1 && sbQ.size() > 0) begin
      expWr = sbQ.pop_front();
      nCompared++; if (mem_wdata !== expWr.data) begin nMismatched++; $display("FAIL b2b_word_sb: got %h want %h", mem_wdata, expWr.data); end
    end
    expCnt++;
    tick();
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("FAIL b2b_c2_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    nCompared++; if (req_ready !== 1'b0 || mem_re !== 1'b1) begin nMismatched++; $display("FAIL b2b_c3: got ready %b re %b want 0 1", req_ready, mem_re); end
    tick();
    nCompared++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin nMismatched++; $display("FAIL b2b_c4: got ready %b we %b want 0 0", req_ready, mem_we); end
    tick();
    nCompared++; if (req_ready !== 1'b0 || done !== 1'b1 || mem_we !== 1'b1) begin nMismatched++; $display("FAIL b2b_c5: got ready %b done %b we %b want 0 1 1", req_ready, done, mem_we); end
    nCompared++;
    if (sbQ.size() == 0) begin nMismatched++; $display("FAIL b2b_byte_sb: got write %h with empty queue", mem_wdata); end
    else begin
      expWr = sbQ.pop_front();
      if (mem_addr !== expWr.addr || mem_wdata !== expWr.data) begin
        nMismatched++; $display("FAIL b2b_byte_sb: got %h@%h want %h@%h", mem_wdata, mem_addr, expWr.data, expWr.addr);
      end
    end
    tick();
    expCnt++;
    nCompared++; if (req_ready !== 1'b1 || store_cnt !== expCnt) begin nMismatched++; $display("FAIL b2b_end: got ready %b cnt %h want 1 %h", req_ready, store_cnt, expCnt); end
  endtask

  task automatic test_reset_mid();
    ram[24] = 32'hCAFE_F00D;
    setReq(1'b1, 32'h63, 32'h0000_0055, 2'b00);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    nCompared++; if ({mem_we, done, req_ready} !== 3'b000 || store_cnt !== 16'h0) begin nMismatched++; $display("FAIL rstmid_during: got we/done/ready %b cnt %h want 000 0000", {mem_we, done, req_ready}, store_cnt); end
    reset = 1'b0;
    #1;
    nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("FAIL rstmid_idle: got ready %b want 1", req_ready); end
    tick();
    nCompared++; if (mem_we !== 1'b0 || ram[24] !== 32'hCAFE_F00D) begin nMismatched++; $display("FAIL rstmid_ram: got we %b ram %h want 0 cafef00d", mem_we, ram[24]); end
    expCnt = 16'h0;
    setReq(1'b1, 32'h60, 32'h1357_2468, 2'b10);
    tick();
    req_valid = 1'b0;
    nCompared++; if (mem_we !== 1'b1 || done !== 1'b1 || mem_wdata !== 32'h1357_2468) begin nMismatched++; $display("FAIL rstmid_word: got we %b done %b wdata %h want 1 1 13572468", mem_we, done, mem_wdata); end
    tick();
    expCnt++;
    nCompared++; if (store_cnt !== expCnt || ram[24] !== 32'h1357_2468) begin nMismatched++; $display("FAIL rstmid_after: got cnt %h ram %h want %h 13572468", store_cnt, ram[24], expCnt); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        bad;
    int          r;
    int          expErr = 0;
    int          errSeen = 0;
    for (int w = 32; w < 64; w++) begin
      ram[w]    = $urandom;
      shadow[w] = ram[w];
    end
    for (int i = 0; i < 40; i++) begin
      a = 32'h80 + 32'($urandom_range(0, 127));
      d = $urandom;
      r = $urandom_range(0, 9);
      s = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      bad = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
      if (bad) begin
        expErr++;
      end else begin
        shadow[a[9:2]] = mergeModel(shadow[a[9:2]], a, d, s);
        sbQ.push_back('{addr: {a[31:2], 2'b00}, data: shadow[a[9:2]]});
        expCnt++;
      end
      setReq(1'b1, a, d, s);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 8 && req_ready !== 1'b1; k++) begin
        if (err === 1'b1) errSeen++;
        if (mem_we === 1'b1) begin
          nCompared++;
          if (sbQ.size() == 0) begin nMismatched++; $display("FAIL rand%0d_sb: got write %h with empty queue", i, mem_wdata); end
          else begin
            expWr = sbQ.pop_front();
            if (mem_addr !== expWr.addr || mem_wdata !== expWr.data) begin
              nMismatched++; $display("FAIL rand%0d_sb: got %h@%h want %h@%h", i, mem_wdata, mem_addr, expWr.data, expWr.addr);
            end
          end
        end
        tick();
      end
      nCompared++; if (req_ready !== 1'b1) begin nMismatched++; $display("FAIL rand%0d_timeout: got ready %b want 1", i, req_ready); end
    end
    nCompared++; if (errSeen != expErr) begin nMismatched++; $display("FAIL rand_errs: got %0d want %0d", errSeen, expErr); end
    nCompared++; if (store_cnt !== expCnt) begin nMismatched++; $display("FAIL rand_cnt: got %h want %h", store_cnt, expCnt); end
    nCompared++; if (sbQ.size() != 0) begin nMismatched++; $display("FAIL rand_leftover: got %0d pending want 0", sbQ.size()); end
    for (int w = 32; w < 64; w++) begin
      nCompared++; if (ram[w] !== shadow[w]) begin nMismatched++; $display("FAIL rand_ram%0d: got %h want %h", w, ram[w], shadow[w]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_rdata = 32'h0;
    expCnt    = 16'h0;
    setReq(1'b0, 32'h0, 32'h0, 2'b00);
    for (int w = 0; w < 256; w++) ram[w] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side byte-lane writer for the CPU's data memory. It is the write counterpart to the load path that extracts and sign-extends bytes and halfwords. It accepts sb/sh/sw requests from the MEM stage and performs each one against a word-only data RAM. Byte and halfword stores use a read-modify-write sequence; aligned word stores are written directly. Misaligned or reserved requests are rejected without touching memory.

## Interface
- No parameters; data and address width fixed at 32 bits, little-endian lane order.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept; equals (state==IDLE) & ~reset
- req_addr  in  32  byte address of store
- req_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- done  out  1  one-cycle pulse, high in the cycle the write is issued
- err  out  1  one-cycle pulse for misaligned/reserved request
- mem_addr  out  32  word address to RAM, {latched_addr[31:2], 2'b00}
- mem_re  out  1  RAM read strobe
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re
- mem_we  out  1  RAM write strobe
- mem_wdata  out  32  RAM write data
- store_cnt  out  16  count of completed stores (done pulses), wraps FFFF→0000

## Operation
- States: IDLE, READ, MERGE, WRITE, ERR.
- All outputs except req_ready are decoded from registered state/latches only; no combinational path from req_* to mem_*.
- IDLE: req_ready=1. On req_valid & req_ready, latch addr/data/size, then select the next state:
  - size 11, or size 01 with addr[0]=1, or size 10 with addr[1:0]≠00 → ERR.
  - size 10 aligned → WRITE; mem_wdata = latched data.
  - size 00 or size 01 aligned → READ.
- READ: mem_re=1, mem_addr driven → MERGE.
- MERGE: sample mem_rdata and form the merged word into a register → WRITE.
  - Byte: lane k=addr[1:0]; bits [8k+7:8k] ← data[7:0], all other bits from rdata.
  - Half: lane h=addr[1]; bits [16h+15:16h] ← data[15:0], other half from rdata.
- WRITE: mem_we=1, mem_wdata = merged or direct word, done=1, store_cnt+1 at the clock edge → IDLE.
- ERR: err=1; no mem_re/mem_we → IDLE.
- req_data bits above the store size are ignored.
- Outside the states above, mem_re, mem_we, done and err are 0. mem_addr and mem_wdata hold their last values and are don't-care when their strobe is low.

## Timing
- Request accepted at edge 0 (cycle 0 = accept cycle).
- Word: WRITE in cycle 1; req_ready high again in cycle 2. 2-cycle occupancy.
- Byte/half: READ cycle 1, MERGE cycle 2, WRITE cycle 3, ready cycle 4. 4-cycle occupancy.
- Error: ERR cycle 1 (err=1), ready cycle 2.
- Back-to-back: a new request may be accepted in the first cycle req_ready is high again. Requests presented while req_ready=0 are not accepted and must be held by the source.
- Reset values: state IDLE, mem_re=0, mem_we=0, done=0, err=0, store_cnt=0, latches=0, mem_addr=0, mem_wdata=0.
- While reset is high: req_ready=0 and no request is accepted.
- Reset during READ/MERGE/WRITE: that edge forces IDLE.
  - No mem_we follows and no done pulse.
  - store_cnt clears to 0.
  - The abandoned store is lost; the memory is unmodified unless WRITE had already been sampled by the RAM before the edge.
- Reset and req_valid in the same cycle: reset wins and the request is not accepted.
- store_cnt increments only on done, never on err.

## Test plan
- Word store: addr 0x0000_0010, data 0xDEAD_BEEF, size 10 → cycle 1: mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1; no mem_re; store_cnt=1.
- Byte store: RAM[0x20]=0x1122_3344; addr 0x22, data 0xFFFF_FFAB, size 00.
  - Cycle 1: mem_re=1 with mem_addr=0x20.
  - Cycle 3: mem_we=1 with mem_wdata=0x11AB_3344 and done=1.
- Half store: RAM[0x40]=0xAAAA_BBBB; addr 0x42, data 0x0000_1234, size 01 → mem_wdata=0x1234_BBBB. Repeat at addr 0x40 → 0x1234_1234.
- Errors: (addr 0x31, size 01), (addr 0x32, size 10) and (addr 0x30, size 11) each produce err=1 in cycle 1, no mem_re/mem_we, store_cnt unchanged.
- Back-to-back: word store, then a byte store presented continuously → second store accepted in cycle 2 and its done lands in cycle 5. Check req_ready low in cycles 1 and 3-5.
- Reset mid-operation: assert reset during MERGE of a byte store → no mem_we, state IDLE, store_cnt=0. The RAM word is unchanged, and a subsequent word store completes normally.
